cdc_flag_sender: RTL

//   Launching side of a four-phase req/ack flag crossing. Turns single-cycle PULSE_IN

---
 rtl/cdc_flag_pkg.sv | 16 +
 rtl/cdc_ack_sync.sv | 29 ++
 rtl/cdc_flag_sender.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cdc_flag_pkg.sv
// Shared types for the req/ack flag sender: handshake FSM states and drop-counter width.
package cdc_flag_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int DROP_CNT_W = 16;

    function automatic logic [DROP_CNT_W-1:0] sat_inc16(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cdc_ack_sync.sv
// Multi-flop synchronizer for the far-domain acknowledge; output is the last stage.
module cdc_ack_sync #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_flag_sender.sv
// Launching side of a four-phase req/ack flag crossing with a saturating event queue.
// Optional dropped-event counter port enabled by `CDC_FLAG_SENDER_DROP_CNT_EN.
module cdc_flag_sender
    import cdc_flag_pkg::*;
#(
    parameter int CNT_WIDTH   = 4,
    parameter int SYNC_STAGES = 3
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  PULSE_IN,
    input  logic                  ACK_IN,
    input  logic                  CLR_OVF,
    output logic                  REQ_OUT,
    output logic                  BUSY,
    output logic [CNT_WIDTH-1:0]  PENDING,
`ifdef CDC_FLAG_SENDER_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] DROP_CNT,
`endif
    output logic                  OVERFLOW
);

    localparam logic [CNT_WIDTH-1:0] PEND_MAX = '1;

    logic                 ack_s;
    state_e               state_q, state_d;
    logic                 req_q, req_d;
    logic                 busy_q, busy_d;
    logic [CNT_WIDTH-1:0] pend_q, pend_d;
    logic                 ovf_q, ovf_d;
    logic                 launch, dequeue, pulse_taken, pulse_queued, drop;

    cdc_ack_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (CLK),
        .rst_n (RESET_N),
        .d     (ACK_IN),
        .q     (ack_s)
    );

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        dequeue     = 1'b0;
        pulse_taken = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ack_s && (PULSE_IN || pend_q != '0)) begin
                    launch = 1'b1;
                    if (pend_q != '0) dequeue = 1'b1;
                    else              pulse_taken = 1'b1;
                end
            end
            REQ: begin
                if (ack_s) state_d = RELEASE;
            end
            RELEASE: begin
                if (!ack_s) begin
                    if (pend_q != '0) begin
                        launch  = 1'b1;
                        dequeue = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (launch) state_d = REQ;

        req_d  = (state_d == REQ);
        busy_d = (state_d != IDLE);

        // Queued events are always launched before a same-cycle pulse, keeping order.
        pulse_queued = PULSE_IN && !pulse_taken;
        drop         = pulse_queued && !dequeue && (pend_q == PEND_MAX);
        pend_d       = pend_q;
        if (pulse_queued && !dequeue && !drop) begin
            pend_d = pend_q + 1'b1;
        end else if (dequeue && !pulse_queued) begin
            pend_d = pend_q - 1'b1;
        end

        if (drop)         ovf_d = 1'b1;
        else if (CLR_OVF) ovf_d = 1'b0;
        else              ovf_d = ovf_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef CDC_FLAG_SENDER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        if (drop)         drop_cnt_d = sat_inc16(drop_cnt_q);
        else if (CLR_OVF) drop_cnt_d = '0;
        else              drop_cnt_d = drop_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign DROP_CNT = drop_cnt_q;
`endif

    assign REQ_OUT  = req_q;
    assign BUSY     = busy_q;
    assign PENDING  = pend_q;
    assign OVERFLOW = ovf_q;

endmodule
